// File: rtl/axi_slave_mem.sv
// AXI3 memory responder: independent write and read burst engines over an internal
// word-addressed SRAM, supporting FIXED/INCR/WRAP bursts with per-beat SLVERR detection.
module axi_slave_mem #(
   parameter int ID_WIDTH   = 4,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int STRB_WIDTH = DATA_WIDTH/8,
   parameter int LEN_WIDTH  = 8,
   parameter int MEM_DEPTH  = 1024
) (
   input  logic                  ACLK,
   input  logic                  ARESET,
   input  logic [ID_WIDTH-1:0]   AWID,
   input  logic [ADDR_WIDTH-1:0] AWADDR,
   input  logic [LEN_WIDTH-1:0]  AWLEN,
   input  logic [2:0]            AWSIZE,
   input  logic [1:0]            AWBURST,
   input  logic [1:0]            AWLOCK,
   input  logic [3:0]            AWCACHE,
   input  logic [2:0]            AWPROT,
   input  logic                  AWVALID,
   output logic                  AWREADY,
   input  logic [ID_WIDTH-1:0]   WID,
   input  logic [DATA_WIDTH-1:0] WDATA,
   input  logic [STRB_WIDTH-1:0] WSTRB,
   input  logic                  WLAST,
   input  logic                  WVALID,
   output logic                  WREADY,
   output logic [ID_WIDTH-1:0]   BID,
   output logic [1:0]            BRESP,
   output logic                  BVALID,
   input  logic                  BREADY,
   input  logic [ID_WIDTH-1:0]   ARID,
   input  logic [ADDR_WIDTH-1:0] ARADDR,
   input  logic [LEN_WIDTH-1:0]  ARLEN,
   input  logic [2:0]            ARSIZE,
   input  logic [1:0]            ARBURST,
   input  logic [1:0]            ARLOCK,
   input  logic [3:0]            ARCACHE,
   input  logic [2:0]            ARPROT,
   input  logic                  ARVALID,
   output logic                  ARREADY,
   output logic [ID_WIDTH-1:0]   RID,
   output logic [DATA_WIDTH-1:0] RDATA,
   output logic [1:0]            RRESP,
   output logic                  RLAST,
   output logic                  RVALID,
   input  logic                  RREADY
);
   localparam int BYTE_SHIFT = $clog2(STRB_WIDTH);
   localparam int IDX_WIDTH  = $clog2(MEM_DEPTH);
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_WRAP  = 2'b10;
   localparam logic [1:0] BURST_RSVD  = 2'b11;

   typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_t;
   typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_t;

   function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] addr,
      input logic [2:0] size, input logic [LEN_WIDTH-1:0] len, input logic [1:0] burst);
      logic [ADDR_WIDTH-1:0] step;
      logic [ADDR_WIDTH-1:0] mask;
      step = ADDR_WIDTH'(1'b1) << size;
      mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1'b1)) << size) - ADDR_WIDTH'(1'b1);
      case (burst)
         BURST_FIXED: next_addr = addr;
         BURST_WRAP:  next_addr = (addr & ~mask) | ((addr + step) & mask);
         default:     next_addr = addr + step;
      endcase
   endfunction

   function automatic logic burst_err(input logic [2:0] size, input logic [LEN_WIDTH-1:0] len,
      input logic [1:0] burst);
      logic wrap_len_ok;
      wrap_len_ok = (len == LEN_WIDTH'(4'd1)) || (len == LEN_WIDTH'(4'd3)) ||
                    (len == LEN_WIDTH'(4'd7)) || (len == LEN_WIDTH'(4'd15));
      burst_err = (int'(size) > BYTE_SHIFT) || (burst == BURST_RSVD) ||
                  ((burst == BURST_WRAP) && !wrap_len_ok);
   endfunction

   function automatic logic idx_err(input logic [ADDR_WIDTH-1:0] addr);
      idx_err = (addr >> BYTE_SHIFT) >= ADDR_WIDTH'(MEM_DEPTH);
   endfunction

   function automatic logic [IDX_WIDTH-1:0] word_idx(input logic [ADDR_WIDTH-1:0] addr);
      word_idx = IDX_WIDTH'(addr >> BYTE_SHIFT);
   endfunction

   logic [DATA_WIDTH-1:0] mem_r [MEM_DEPTH];

   w_state_t              w_state_r, w_state_s;
   logic [ID_WIDTH-1:0]   w_id_r, w_id_s;
   logic [ADDR_WIDTH-1:0] w_addr_r, w_addr_s;
   logic [LEN_WIDTH-1:0]  w_len_r, w_len_s, w_beat_r, w_beat_s;
   logic [2:0]            w_size_r, w_size_s;
   logic [1:0]            w_burst_r, w_burst_s;
   logic                  w_berr_r, w_berr_s, w_sticky_r, w_sticky_s;
   logic                  awready_r, awready_s, wready_r, wready_s, bvalid_r, bvalid_s;
   logic [ID_WIDTH-1:0]   bid_r, bid_s;
   logic [1:0]            bresp_r, bresp_s;
   logic                  aw_hs_s, w_hs_s, b_hs_s, w_last_beat_s, w_beat_err_s, mem_we_s;
   logic [IDX_WIDTH-1:0]  mem_widx_s;

   r_state_t              r_state_r, r_state_s;
   logic [ADDR_WIDTH-1:0] r_addr_r, r_addr_s, r_src_addr_s;
   logic [LEN_WIDTH-1:0]  r_len_r, r_len_s, r_beat_r, r_beat_s;
   logic [2:0]            r_size_r, r_size_s;
   logic [1:0]            r_burst_r, r_burst_s;
   logic                  r_berr_r, r_berr_s, r_src_err_s;
   logic [DATA_WIDTH-1:0] r_src_data_s;
   logic                  arready_r, arready_s, rvalid_r, rvalid_s, rlast_r, rlast_s;
   logic [ID_WIDTH-1:0]   rid_r, rid_s;
   logic [DATA_WIDTH-1:0] rdata_r, rdata_s;
   logic [1:0]            rresp_r, rresp_s;
   logic                  ar_hs_s, r_hs_s;
   logic                  unused_s;

   assign unused_s = ^{AWLOCK, AWCACHE, AWPROT, ARLOCK, ARCACHE, ARPROT};

   assign aw_hs_s       = AWVALID && awready_r;
   assign w_hs_s        = WVALID && wready_r;
   assign b_hs_s        = BREADY && bvalid_r;
   assign w_last_beat_s = (w_beat_r == w_len_r);
   assign w_beat_err_s  = w_berr_r || idx_err(w_addr_r) || (WLAST != w_last_beat_s) || (WID != w_id_r);
   assign mem_widx_s    = word_idx(w_addr_r);

   // Write engine state, burst context and registered write-channel outputs
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         w_state_r  <= W_IDLE;
         w_id_r     <= {ID_WIDTH{1'b0}};
         w_addr_r   <= {ADDR_WIDTH{1'b0}};
         w_len_r    <= {LEN_WIDTH{1'b0}};
         w_beat_r   <= {LEN_WIDTH{1'b0}};
         w_size_r   <= 3'd0;
         w_burst_r  <= 2'd0;
         w_berr_r   <= 1'b0;
         w_sticky_r <= 1'b0;
         awready_r  <= 1'b0;
         wready_r   <= 1'b0;
         bvalid_r   <= 1'b0;
         bid_r      <= {ID_WIDTH{1'b0}};
         bresp_r    <= 2'd0;
      end else begin
         w_state_r  <= w_state_s;
         w_id_r     <= w_id_s;
         w_addr_r   <= w_addr_s;
         w_len_r    <= w_len_s;
         w_beat_r   <= w_beat_s;
         w_size_r   <= w_size_s;
         w_burst_r  <= w_burst_s;
         w_berr_r   <= w_berr_s;
         w_sticky_r <= w_sticky_s;
         awready_r  <= awready_s;
         wready_r   <= wready_s;
         bvalid_r   <= bvalid_s;
         bid_r      <= bid_s;
         bresp_r    <= bresp_s;
      end
   end

   // Write engine next-state decode
   always_comb begin
      w_state_s = w_state_r;
      case (w_state_r)
         W_IDLE:  if (aw_hs_s) w_state_s = W_DATA; else w_state_s = W_IDLE;
         W_DATA:  if (w_hs_s && w_last_beat_s) w_state_s = W_RESP; else w_state_s = W_DATA;
         W_RESP:  if (b_hs_s) w_state_s = W_IDLE; else w_state_s = W_RESP;
         default: w_state_s = W_IDLE;
      endcase
   end

   // Write engine outputs, context updates and SRAM write enable
   always_comb begin
      awready_s  = awready_r;
      wready_s   = wready_r;
      bvalid_s   = bvalid_r;
      bid_s      = bid_r;
      bresp_s    = bresp_r;
      w_id_s     = w_id_r;
      w_addr_s   = w_addr_r;
      w_len_s    = w_len_r;
      w_beat_s   = w_beat_r;
      w_size_s   = w_size_r;
      w_burst_s  = w_burst_r;
      w_berr_s   = w_berr_r;
      w_sticky_s = w_sticky_r;
      mem_we_s   = 1'b0;
      case (w_state_r)
         W_IDLE: begin
            if (aw_hs_s) begin
               awready_s  = 1'b0;
               wready_s   = 1'b1;
               w_id_s     = AWID;
               w_addr_s   = AWADDR;
               w_len_s    = AWLEN;
               w_size_s   = AWSIZE;
               w_burst_s  = AWBURST;
               w_berr_s   = burst_err(AWSIZE, AWLEN, AWBURST);
               w_beat_s   = {LEN_WIDTH{1'b0}};
               w_sticky_s = 1'b0;
            end else begin
               awready_s = 1'b1;
            end
         end
         W_DATA: begin
            if (w_hs_s) begin
               mem_we_s   = !w_beat_err_s;
               w_sticky_s = w_sticky_r || w_beat_err_s;
               w_addr_s   = next_addr(w_addr_r, w_size_r, w_len_r, w_burst_r);
               w_beat_s   = w_beat_r + LEN_WIDTH'(1'b1);
               if (w_last_beat_s) begin
                  wready_s = 1'b0;
                  bvalid_s = 1'b1;
                  bid_s    = w_id_r;
                  bresp_s  = (w_sticky_r || w_beat_err_s) ? RESP_SLVERR : RESP_OKAY;
               end else begin
                  wready_s = 1'b1;
               end
            end else begin
               wready_s = 1'b1;
            end
         end
         W_RESP: begin
            if (b_hs_s) begin
               bvalid_s  = 1'b0;
               bid_s     = {ID_WIDTH{1'b0}};
               bresp_s   = RESP_OKAY;
               awready_s = 1'b1;
            end else begin
               bvalid_s = 1'b1;
            end
         end
         default: begin
            awready_s = 1'b0;
            wready_s  = 1'b0;
            bvalid_s  = 1'b0;
         end
      endcase
   end

   // SRAM byte-lane write port; contents intentionally survive reset
   always_ff @(posedge ACLK) begin
      if (mem_we_s) begin
         for (int i = 0; i < STRB_WIDTH; i++) begin
            if (WSTRB[i]) mem_r[mem_widx_s][8*i +: 8] <= WDATA[8*i +: 8];
         end
      end
   end

   assign ar_hs_s      = ARVALID && arready_r;
   assign r_hs_s       = RREADY && rvalid_r;
   assign r_src_addr_s = (r_state_r == R_IDLE) ? ARADDR : r_addr_r;
   assign r_src_err_s  = ((r_state_r == R_IDLE) ? burst_err(ARSIZE, ARLEN, ARBURST) : r_berr_r) ||
                         idx_err(r_src_addr_s);
   // The read is registered, so a same-edge write is not yet visible here
   assign r_src_data_s = r_src_err_s ? {DATA_WIDTH{1'b0}} : mem_r[word_idx(r_src_addr_s)];

   // Read engine state, burst context and registered read-channel outputs
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         r_state_r <= R_IDLE;
         r_addr_r  <= {ADDR_WIDTH{1'b0}};
         r_len_r   <= {LEN_WIDTH{1'b0}};
         r_beat_r  <= {LEN_WIDTH{1'b0}};
         r_size_r  <= 3'd0;
         r_burst_r <= 2'd0;
         r_berr_r  <= 1'b0;
         arready_r <= 1'b0;
         rvalid_r  <= 1'b0;
         rlast_r   <= 1'b0;
         rid_r     <= {ID_WIDTH{1'b0}};
         rdata_r   <= {DATA_WIDTH{1'b0}};
         rresp_r   <= 2'd0;
      end else begin
         r_state_r <= r_state_s;
         r_addr_r  <= r_addr_s;
         r_len_r   <= r_len_s;
         r_beat_r  <= r_beat_s;
         r_size_r  <= r_size_s;
         r_burst_r <= r_burst_s;
         r_berr_r  <= r_berr_s;
         arready_r <= arready_s;
         rvalid_r  <= rvalid_s;
         rlast_r   <= rlast_s;
         rid_r     <= rid_s;
         rdata_r   <= rdata_s;
         rresp_r   <= rresp_s;
      end
   end

   // Read engine next-state decode
   always_comb begin
      r_state_s = r_state_r;
      case (r_state_r)
         R_IDLE:  if (ar_hs_s) r_state_s = R_DATA; else r_state_s = R_IDLE;
         R_DATA:  if (r_hs_s && rlast_r) r_state_s = R_IDLE; else r_state_s = R_DATA;
         default: r_state_s = R_IDLE;
      endcase
   end

   // Read engine outputs and beat sequencing
   always_comb begin
      arready_s = arready_r;
      rvalid_s  = rvalid_r;
      rlast_s   = rlast_r;
      rid_s     = rid_r;
      rdata_s   = rdata_r;
      rresp_s   = rresp_r;
      r_addr_s  = r_addr_r;
      r_len_s   = r_len_r;
      r_beat_s  = r_beat_r;
      r_size_s  = r_size_r;
      r_burst_s = r_burst_r;
      r_berr_s  = r_berr_r;
      case (r_state_r)
         R_IDLE: begin
            if (ar_hs_s) begin
               arready_s = 1'b0;
               rvalid_s  = 1'b1;
               rid_s     = ARID;
               rdata_s   = r_src_data_s;
               rresp_s   = r_src_err_s ? RESP_SLVERR : RESP_OKAY;
               rlast_s   = (ARLEN == {LEN_WIDTH{1'b0}});
               r_addr_s  = next_addr(ARADDR, ARSIZE, ARLEN, ARBURST);
               r_len_s   = ARLEN;
               r_size_s  = ARSIZE;
               r_burst_s = ARBURST;
               r_berr_s  = burst_err(ARSIZE, ARLEN, ARBURST);
               r_beat_s  = {LEN_WIDTH{1'b0}};
            end else begin
               arready_s = 1'b1;
            end
         end
         R_DATA: begin
            if (r_hs_s) begin
               if (rlast_r) begin
                  rvalid_s  = 1'b0;
                  rlast_s   = 1'b0;
                  rid_s     = {ID_WIDTH{1'b0}};
                  rdata_s   = {DATA_WIDTH{1'b0}};
                  rresp_s   = RESP_OKAY;
                  arready_s = 1'b1;
               end else begin
                  rdata_s  = r_src_data_s;
                  rresp_s  = r_src_err_s ? RESP_SLVERR : RESP_OKAY;
                  rlast_s  = ((r_beat_r + LEN_WIDTH'(1'b1)) == r_len_r);
                  r_beat_s = r_beat_r + LEN_WIDTH'(1'b1);
                  r_addr_s = next_addr(r_addr_r, r_size_r, r_len_r, r_burst_r);
               end
            end else begin
               rvalid_s = 1'b1;
            end
         end
         default: begin
            arready_s = 1'b0;
            rvalid_s  = 1'b0;
            rlast_s   = 1'b0;
         end
      endcase
   end

   assign AWREADY = awready_r;
   assign WREADY  = wready_r;
   assign BVALID  = bvalid_r;
   assign BID     = bid_r;
   assign BRESP   = bresp_r;
   assign ARREADY = arready_r;
   assign RVALID  = rvalid_r;
   assign RLAST   = rlast_r;
   assign RID     = rid_r;
   assign RDATA   = rdata_r;
   assign RRESP   = rresp_r;

endmodule

// File: tb/tb_axi_slave_mem.sv
// Directed self-checking bench for axi_slave_mem: bursts, strobes, errors,
// backpressure and mid-burst reset against hand-computed expectations.
module tb_axi_slave_mem;
   localparam int TMO = 20;

   logic        ACLK = 1'b0;
   logic        ARESET = 1'b1;
   logic [3:0]  AWID = 4'd0, WID = 4'd0, BID, ARID = 4'd0, RID;
   logic [31:0] AWADDR = 32'd0, ARADDR = 32'd0, WDATA = 32'd0, RDATA;
   logic [7:0]  AWLEN = 8'd0, ARLEN = 8'd0;
   logic [2:0]  AWSIZE = 3'd0, ARSIZE = 3'd0;
   logic [1:0]  AWBURST = 2'd0, ARBURST = 2'd0, BRESP, RRESP;
   logic [3:0]  WSTRB = 4'd0;
   logic        AWVALID = 1'b0, AWREADY, WLAST = 1'b0, WVALID = 1'b0, WREADY;
   logic        BVALID, BREADY = 1'b0, ARVALID = 1'b0, ARREADY;
   logic        RLAST, RVALID, RREADY = 1'b0;

   logic [31:0] wdata_a [16];
   logic [31:0] exp_data [16];
   logic [1:0]  exp_rresp [16];
   int          n_checks = 0;
   int          n_fail = 0;

   always #5 ACLK = ~ACLK;

   axi_slave_mem dut (
      .ACLK(ACLK), .ARESET(ARESET),
      .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
      .AWLOCK(2'b00), .AWCACHE(4'b0000), .AWPROT(3'b000), .AWVALID(AWVALID), .AWREADY(AWREADY),
      .WID(WID), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
      .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
      .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
      .ARLOCK(2'b00), .ARCACHE(4'b0000), .ARPROT(3'b000), .ARVALID(ARVALID), .ARREADY(ARREADY),
      .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
   );

   task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] outs_vec();
      outs_vec = {14'd0, AWREADY, WREADY, BVALID, BID, BRESP, ARREADY, RVALID, RID, RDATA, RRESP, RLAST};
   endfunction

   task automatic send_aw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
      int n = 0;
      AWID = id; AWADDR = addr; AWLEN = len; AWSIZE = size; AWBURST = burst; AWVALID = 1'b1;
      while (!AWREADY && n < TMO) begin @(posedge ACLK); #1; n++; end
      if (!AWREADY) check_value("aw_timeout", AWREADY, 1'b1);
      @(posedge ACLK); #1;
      AWVALID = 1'b0;
   endtask

   task automatic send_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
      int n = 0;
      ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = size; ARBURST = burst; ARVALID = 1'b1;
      while (!ARREADY && n < TMO) begin @(posedge ACLK); #1; n++; end
      if (!ARREADY) check_value("ar_timeout", ARREADY, 1'b1);
      @(posedge ACLK); #1;
      ARVALID = 1'b0;
   endtask

   task automatic send_w(input int nbeats, input int len, input logic [3:0] strb, input logic [3:0] id);
      for (int b = 0; b < nbeats; b++) begin
         int n = 0;
         WID = id; WDATA = wdata_a[b]; WSTRB = strb; WLAST = (b == len); WVALID = 1'b1;
         while (!WREADY && n < TMO) begin @(posedge ACLK); #1; n++; end
         if (!WREADY) check_value("w_timeout", WREADY, 1'b1);
         @(posedge ACLK); #1;
      end
      WVALID = 1'b0; WLAST = 1'b0;
   endtask

   task automatic recv_b(input logic [3:0] exp_id, input logic [1:0] exp_resp, input int bstall);
      int n = 0;
      while (!BVALID && n < TMO) begin @(posedge ACLK); #1; n++; end
      check_value("bvalid", BVALID, 1'b1);
      check_value("bid", BID, exp_id);
      check_value("bresp", BRESP, exp_resp);
      for (int s = 0; s < bstall; s++) begin
         @(posedge ACLK); #1;
         check_value("b_stall_bvalid", BVALID, 1'b1);
         check_value("b_stall_awready", AWREADY, 1'b0);
         check_value("b_stall_bresp", BRESP, exp_resp);
      end
      BREADY = 1'b1;
      @(posedge ACLK); #1;
      BREADY = 1'b0;
      check_value("b_done_bvalid", BVALID, 1'b0);
      check_value("b_done_awready", AWREADY, 1'b1);
   endtask

   task automatic recv_r(input logic [3:0] exp_id, input int len, input int stall);
      for (int b = 0; b <= len; b++) begin
         int n = 0;
         while (!RVALID && n < TMO) begin @(posedge ACLK); #1; n++; end
         check_value($sformatf("rvalid[%0d]", b), RVALID, 1'b1);
         check_value($sformatf("rdata[%0d]", b), RDATA, exp_data[b]);
         check_value($sformatf("rresp[%0d]", b), RRESP, exp_rresp[b]);
         check_value($sformatf("rlast[%0d]", b), RLAST, (b == len));
         check_value($sformatf("rid[%0d]", b), RID, exp_id);
         if (b == 0) begin
            for (int s = 0; s < stall; s++) begin
               @(posedge ACLK); #1;
               check_value("r_stall_rvalid", RVALID, 1'b1);
               check_value("r_stall_rdata", RDATA, exp_data[0]);
               check_value("r_stall_rlast", RLAST, (len == 0));
            end
         end
         RREADY = 1'b1;
         @(posedge ACLK); #1;
         RREADY = 1'b0;
      end
      check_value("r_done_rvalid", RVALID, 1'b0);
      check_value("r_done_arready", ARREADY, 1'b1);
   endtask

   task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input logic [3:0] strb,
                           input logic [1:0] exp_resp, input int bstall);
      send_aw(id, addr, len, 3'd2, burst);
      send_w(int'(len) + 1, int'(len), strb, id);
      recv_b(id, exp_resp, bstall);
   endtask

   task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input int stall);
      send_ar(id, addr, len, size, burst);
      recv_r(id, int'(len), stall);
   endtask

   task automatic set_exp4(input logic [31:0] d0, input logic [31:0] d1,
                           input logic [31:0] d2, input logic [31:0] d3);
      exp_data[0] = d0; exp_data[1] = d1; exp_data[2] = d2; exp_data[3] = d3;
      for (int i = 0; i < 16; i++) exp_rresp[i] = 2'b00;
   endtask

   initial begin
      // Reset state and ready rise one cycle after release
      repeat (3) @(posedge ACLK);
      #1;
      check_value("reset_outputs", outs_vec(), 64'd0);
      ARESET = 1'b0;
      check_value("awready_at_release", AWREADY, 1'b0);
      @(posedge ACLK); #1;
      check_value("awready_post_release", AWREADY, 1'b1);
      check_value("arready_post_release", ARREADY, 1'b1);

      // INCR burst write and readback
      wdata_a[0] = 32'hA000_0000; wdata_a[1] = 32'hA111_1111;
      wdata_a[2] = 32'hA222_2222; wdata_a[3] = 32'hA333_3333;
      do_write(4'd5, 32'h100, 8'd3, 2'b01, 4'hF, 2'b00, 0);
      set_exp4(32'hA000_0000, 32'hA111_1111, 32'hA222_2222, 32'hA333_3333);
      do_read(4'd3, 32'h100, 8'd3, 3'd2, 2'b01, 0);

      // WRAP write starting at 0x10C lands 1,2,3,4 at 0x10C,0x100,0x104,0x108
      wdata_a[0] = 32'd1; wdata_a[1] = 32'd2; wdata_a[2] = 32'd3; wdata_a[3] = 32'd4;
      do_write(4'd6, 32'h10C, 8'd3, 2'b10, 4'hF, 2'b00, 0);
      set_exp4(32'd2, 32'd3, 32'd4, 32'd1);
      do_read(4'd7, 32'h100, 8'd3, 3'd2, 2'b01, 0);
      set_exp4(32'd4, 32'd1, 32'd2, 32'd3);
      do_read(4'd8, 32'h108, 8'd3, 3'd2, 2'b10, 0);

      // Partial strobe merge
      wdata_a[0] = 32'h1122_3344;
      do_write(4'd1, 32'h200, 8'd0, 2'b01, 4'hF, 2'b00, 0);
      wdata_a[0] = 32'hDEAD_BEEF;
      do_write(4'd2, 32'h200, 8'd0, 2'b01, 4'b0101, 2'b00, 0);
      set_exp4(32'h11AD_33EF, 32'd0, 32'd0, 32'd0);
      do_read(4'd2, 32'h200, 8'd0, 3'd2, 2'b01, 0);

      // Out-of-range burst: SLVERR, nothing stored (word 0 must not be aliased)
      wdata_a[0] = 32'h0123_4567;
      do_write(4'd4, 32'h0, 8'd0, 2'b01, 4'hF, 2'b00, 0);
      wdata_a[0] = 32'h5555_5555; wdata_a[1] = 32'h6666_6666;
      do_write(4'd4, 32'h1000, 8'd1, 2'b01, 4'hF, 2'b10, 0);
      set_exp4(32'd0, 32'd0, 32'd0, 32'd0);
      exp_rresp[0] = 2'b10; exp_rresp[1] = 2'b10;
      do_read(4'd9, 32'h1000, 8'd1, 3'd2, 2'b01, 0);
      set_exp4(32'h0123_4567, 32'd0, 32'd0, 32'd0);
      do_read(4'd9, 32'h0, 8'd0, 3'd2, 2'b01, 0);

      // Oversized beat size is an error even for an in-range address
      set_exp4(32'd0, 32'd0, 32'd0, 32'd0);
      exp_rresp[0] = 2'b10;
      do_read(4'd10, 32'h100, 8'd0, 3'd3, 2'b01, 0);

      // Backpressure on R and B channels
      set_exp4(32'd2, 32'd3, 32'd4, 32'd1);
      do_read(4'd11, 32'h100, 8'd3, 3'd2, 2'b01, 3);
      wdata_a[0] = 32'h0F0F_0F0F;
      do_write(4'd12, 32'h204, 8'd0, 2'b01, 4'hF, 2'b00, 5);

      // Reset after two of four write beats
      wdata_a[0] = 32'hC000_0000; wdata_a[1] = 32'hC111_1111;
      wdata_a[2] = 32'hC222_2222; wdata_a[3] = 32'hC333_3333;
      send_aw(4'd13, 32'h300, 8'd3, 3'd2, 2'b01);
      send_w(2, 3, 4'hF, 4'd13);
      ARESET = 1'b1;
      #1;
      check_value("midburst_reset_outputs", outs_vec(), 64'd0);
      @(posedge ACLK); @(posedge ACLK); #1;
      ARESET = 1'b0;
      check_value("midburst_awready_release", AWREADY, 1'b0);
      @(posedge ACLK); #1;
      check_value("midburst_awready_post", AWREADY, 1'b1);
      set_exp4(32'hC000_0000, 32'hC111_1111, 32'd0, 32'd0);
      do_read(4'd14, 32'h300, 8'd1, 3'd2, 2'b01, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
